vsi_cmd_rx: RTL

- Receive side of the COM command link inside vsi. Deserialises 11-bit UART-style bytes from the COM line: start 0, 8 data bits LSB first, odd parity, stop 1, at 1 Mbit/s.
- Assembles the 6-byte command frame: marker, flag, len_hi, len_lo, crc_hi, crc_lo. It then checks the CRC-16.
- Presents the decoded command to the vsi control FSM as a single-cycle pulse, or reports an error code.

---
 rtl/vsi_cmd_rx.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vsi_cmd_rx.sv
// vsi_cmd_rx: receive side of the COM command link.
// Deserialises 11-bit odd-parity bytes from COM, assembles the 6-byte command
// frame (marker, flag, len_hi, len_lo, crc_hi, crc_lo), checks CRC-16/CCITT,
// and presents the result as a cmd_valid or cmd_err pulse.
//
// Bit FSM
//   state    | meaning
//   B_IDLE   | line idle, looking for a low sample (start bit)
//   B_START  | waiting half a bit to confirm the start bit
//   B_DATA   | shifting in 8 data bits, LSB first
//   B_PARITY | sampling the odd-parity bit
//   B_STOP   | sampling the stop bit, then byte-done next cycle
//
// Frame FSM
//   state         | meaning
//   F_WAIT_MARKER | idle, expecting the marker byte
//   F_FLAG        | expecting the flag byte
//   F_LEN_H       | expecting the length high byte
//   F_LEN_L       | expecting the length low byte
//   F_CRC_H       | expecting the CRC high byte
//   F_CRC_L       | expecting the CRC low byte, then compare
module vsi_cmd_rx #(
    parameter int          OVS          = 4,
    parameter logic [7:0]  MARKER       = 8'hA5,
    parameter int          TIMEOUT_BITS = 32
) (
    input  logic        bb_clk_in,
    input  logic        rst_h,
    input  logic        sample_stb,
    input  logic        COM,
    output logic        cmd_valid,
    output logic [7:0]  cmd_flag,
    output logic [15:0] cmd_length,
    output logic        cmd_err,
    output logic [2:0]  err_code,
    output logic        busy
);

    localparam int SMP_W = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [SMP_W-1:0] SMP_FULL = SMP_W'(OVS - 1);
    localparam logic [SMP_W-1:0] SMP_HALF = SMP_W'(OVS / 2 - 1);
    localparam int GAP_LIMIT = TIMEOUT_BITS * OVS;
    localparam int GAP_W = $clog2(GAP_LIMIT);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_LIMIT - 1);

    localparam logic [2:0] ERR_NONE    = 3'b000;
    localparam logic [2:0] ERR_PARITY  = 3'b001;
    localparam logic [2:0] ERR_STOP    = 3'b010;
    localparam logic [2:0] ERR_MARKER  = 3'b011;
    localparam logic [2:0] ERR_CRC     = 3'b100;
    localparam logic [2:0] ERR_TIMEOUT = 3'b101;

    typedef enum logic [2:0] {
        B_IDLE, B_START, B_DATA, B_PARITY, B_STOP
    } bit_state_t;

    typedef enum logic [2:0] {
        F_WAIT_MARKER, F_FLAG, F_LEN_H, F_LEN_L, F_CRC_H, F_CRC_L
    } frame_state_t;

    // CRC-16 x^16+x^12+x^5+1, byte processed MSB first
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i])
                r = {r[14:0], 1'b0} ^ 16'h1021;
            else
                r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic               com_s1, com_s2;
    bit_state_t         bit_state, bit_next;
    logic [SMP_W-1:0]   smp_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               par_err;
    logic               byte_done;
    logic [7:0]         byte_data;
    logic [2:0]         byte_err;
    logic               smp_tick;
    logic               start_det;

    frame_state_t       frame_state, frame_next;
    logic [15:0]        crc_reg;
    logic [7:0]         crc_hi;
    logic [7:0]         flag_sh, lenh_sh, lenl_sh;
    logic               byte_ok;
    logic               crc_match;
    logic               ev_valid, ev_err;
    logic [2:0]         ev_code;
    logic [GAP_W-1:0]   gap_cnt;
    logic               gap_to;

    assign smp_tick  = sample_stb && (smp_cnt == '0);
    assign start_det = sample_stb && (bit_state == B_IDLE) && !com_s2;
    assign busy      = (frame_state != F_WAIT_MARKER);
    assign byte_ok   = byte_done && (byte_err == ERR_NONE);
    assign crc_match = ({crc_hi, byte_data} == crc_reg);

    // Two-flop synchroniser for the asynchronous COM line (idles high)
    always_ff @(posedge bb_clk_in) begin
        if (rst_h) begin
            com_s1 <= 1'b1;
            com_s2 <= 1'b1;
        end else begin
            com_s1 <= COM;
            com_s2 <= com_s1;
        end
    end

    // Bit FSM state register
    always_ff @(posedge bb_clk_in) begin
        if (rst_h)
            bit_state <= B_IDLE;
        else
            bit_state <= bit_next;
    end

    // Bit FSM next-state; a high start re-sample is a false start
    always_comb begin
        bit_next = bit_state;
        case (bit_state)
            B_IDLE:   if (start_det) bit_next = B_START;
            B_START:  if (smp_tick) bit_next = com_s2 ? B_IDLE : B_DATA;
            B_DATA:   if (smp_tick && (bit_cnt == 3'd7)) bit_next = B_PARITY;
            B_PARITY: if (smp_tick) bit_next = B_STOP;
            B_STOP:   if (smp_tick) bit_next = B_IDLE;
            default:  bit_next = B_IDLE;
        endcase
    end

    // Sample down-counter, shift register and byte-done with error code
    always_ff @(posedge bb_clk_in) begin
        if (rst_h) begin
            smp_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err   <= 1'b0;
            byte_done <= 1'b0;
            byte_data <= '0;
            byte_err  <= ERR_NONE;
        end else begin
            byte_done <= 1'b0;
            if (start_det) begin
                smp_cnt <= SMP_HALF;
                bit_cnt <= '0;
            end else if ((bit_state != B_IDLE) && sample_stb) begin
                smp_cnt <= (smp_cnt == '0) ? SMP_FULL : smp_cnt - 1'b1;
            end
            if ((bit_state == B_DATA) && smp_tick) begin
                shreg   <= {com_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if ((bit_state == B_PARITY) && smp_tick)
                par_err <= ~(^shreg ^ com_s2);
            if ((bit_state == B_STOP) && smp_tick) begin
                byte_done <= 1'b1;
                byte_data <= shreg;
                // parity error wins over a simultaneous stop error
                if (par_err)
                    byte_err <= ERR_PARITY;
                else if (!com_s2)
                    byte_err <= ERR_STOP;
                else
                    byte_err <= ERR_NONE;
            end
        end
    end

    // Inter-byte gap down-counter, armed only while a frame is in progress
    always_ff @(posedge bb_clk_in) begin
        if (rst_h) begin
            gap_cnt <= GAP_LOAD;
            gap_to  <= 1'b0;
        end else begin
            gap_to <= 1'b0;
            if (!busy || start_det) begin
                gap_cnt <= GAP_LOAD;
            end else if ((bit_state == B_IDLE) && sample_stb) begin
                if (gap_cnt == '0) begin
                    gap_to  <= 1'b1;
                    gap_cnt <= GAP_LOAD;
                end else begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge bb_clk_in) begin
        if (rst_h)
            frame_state <= F_WAIT_MARKER;
        else
            frame_state <= frame_next;
    end

    // Frame FSM next-state and result events; valid and err are exclusive
    always_comb begin
        frame_next = frame_state;
        ev_valid   = 1'b0;
        ev_err     = 1'b0;
        ev_code    = ERR_NONE;
        if (byte_done) begin
            if (byte_err != ERR_NONE) begin
                ev_err     = 1'b1;
                ev_code    = byte_err;
                frame_next = F_WAIT_MARKER;
            end else begin
                case (frame_state)
                    F_WAIT_MARKER: begin
                        if (byte_data == MARKER) begin
                            frame_next = F_FLAG;
                        end else begin
                            ev_err  = 1'b1;
                            ev_code = ERR_MARKER;
                        end
                    end
                    F_FLAG:  frame_next = F_LEN_H;
                    F_LEN_H: frame_next = F_LEN_L;
                    F_LEN_L: frame_next = F_CRC_H;
                    F_CRC_H: frame_next = F_CRC_L;
                    F_CRC_L: begin
                        frame_next = F_WAIT_MARKER;
                        if (crc_match) begin
                            ev_valid = 1'b1;
                        end else begin
                            ev_err  = 1'b1;
                            ev_code = ERR_CRC;
                        end
                    end
                    default: frame_next = F_WAIT_MARKER;
                endcase
            end
        end else if (gap_to && busy) begin
            ev_err     = 1'b1;
            ev_code    = ERR_TIMEOUT;
            frame_next = F_WAIT_MARKER;
        end
    end

    // CRC accumulation and header shadows; CRC bytes themselves are not fed in
    always_ff @(posedge bb_clk_in) begin
        if (rst_h) begin
            crc_reg <= 16'hFFFF;
            crc_hi  <= '0;
            flag_sh <= '0;
            lenh_sh <= '0;
            lenl_sh <= '0;
        end else if (byte_ok) begin
            case (frame_state)
                F_WAIT_MARKER: if (byte_data == MARKER) crc_reg <= crc16_upd(16'hFFFF, byte_data);
                F_FLAG: begin
                    flag_sh <= byte_data;
                    crc_reg <= crc16_upd(crc_reg, byte_data);
                end
                F_LEN_H: begin
                    lenh_sh <= byte_data;
                    crc_reg <= crc16_upd(crc_reg, byte_data);
                end
                F_LEN_L: begin
                    lenl_sh <= byte_data;
                    crc_reg <= crc16_upd(crc_reg, byte_data);
                end
                F_CRC_H: crc_hi <= byte_data;
                default: ;
            endcase
        end
    end

    // Registered result pulses; decoded fields and error code hold between pulses
    always_ff @(posedge bb_clk_in) begin
        if (rst_h) begin
            cmd_valid  <= 1'b0;
            cmd_err    <= 1'b0;
            err_code   <= ERR_NONE;
            cmd_flag   <= '0;
            cmd_length <= '0;
        end else begin
            cmd_valid <= ev_valid;
            cmd_err   <= ev_err;
            if (ev_err)
                err_code <= ev_code;
            if (ev_valid) begin
                cmd_flag   <= flag_sh;
                cmd_length <= {lenh_sh, lenl_sh};
            end
        end
    end

endmodule
